// File: rtl/cape_apb_pkg.sv
// Shared types for the cape APB initiator: FSM states, bus widths and the
// latched command record.
package cape_apb_pkg;

    localparam int APB_DATA_W     = 32;
    // Widest address the command record can hold; the initiator uses the low ADDR_W bits.
    localparam int APB_ADDR_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_MAX_W-1:0] addr;
        logic [APB_DATA_W-1:0]     wdata;
    } apb_cmd_t;

endpackage

// File: rtl/cape_apb_initiator.sv
// APB3 requester for the cape register slave. Takes one valid/ready command,
// runs a single SETUP/ACCESS transfer and returns the result on a valid/ready
// response stream. One transfer outstanding at a time.
// Optional: define CAPE_APB_TIMEOUT_EN to bound the ACCESS wait to
// TIMEOUT_CYCLES not-ready cycles; expiry returns rsp_err = 1, rsp_rdata = 0.
module cape_apb_initiator
    import cape_apb_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,

    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e            state_q, state_d;
    apb_cmd_t              cmd_q, cmd_d;
    logic [APB_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    // Registered so that cmd_ready reads 0 while reset is held and rises on
    // the first clock after release.
    logic                  cmd_ready_q, cmd_ready_d;

`ifdef CAPE_APB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              wait_expired;

    // Last permitted not-ready cycle; a PREADY in this cycle still wins.
    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, command latch and response capture.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef CAPE_APB_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d.write = cmd_write;
                    cmd_d.addr  = APB_ADDR_MAX_W'({cmd_addr[ADDR_W-1:2], 2'b00});
                    cmd_d.wdata = cmd_wdata;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef CAPE_APB_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    rdata_d = cmd_q.write ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    state_d = RESP;
                end
`ifdef CAPE_APB_TIMEOUT_EN
                else if (wait_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    // State and capture registers; async reset clears everything mid-transfer.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

`ifdef CAPE_APB_TIMEOUT_EN
    // ACCESS wait counter.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) wait_q <= '0;
        else          wait_q <= wait_d;
    end
`endif

    // APB strobes and response valid decode straight from state, so they drop
    // the instant reset asserts.
    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign cmd_ready = cmd_ready_q;

    // Address/data hold their last value outside a transfer.
    assign PADDR     = cmd_q.addr[ADDR_W-1:0];
    assign PWRITE    = cmd_q.write;
    assign PWDATA    = cmd_q.wdata;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Byte-lane address bits, the record's spare upper address bits and the
    // timeout limit (default build) are intentionally dropped here.
    logic unused_bits;
    assign unused_bits = (^{cmd_addr[1:0], cmd_q.addr}) ^ (TIMEOUT_CYCLES == 0);

endmodule
